// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard controller
// Purpose: writeback-source select encoding and hazard FSM state type.
// Ports: none (package).
package hazard_pkg;

  localparam logic [1:0] WB_PC4 = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_ALU = 2'd2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// rtl/hazard_ctrl_mc_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups stage register info, forwarding and stall/flush signals.
// Modports: master = pipeline side (drives stage info, takes controls),
//           slave  = hazard controller.
// Macro HAZARD_PERF_CNT_EN adds perf_stall_cnt/perf_flush_cnt/perf_fw_cnt.
interface hazard_ctrl_mc_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] wR_EX, wR_MEM, wR_WB;
  logic              rf_we_EX, rf_we_MEM, rf_we_WB;
  logic [1:0]        wb_sel_EX, wb_sel_MEM;
  logic [REG_AW-1:0] rR1_ID, rR2_ID;
  logic              rR1_use, rR2_use;
  logic [XLEN-1:0]   pc4_EX, c_EX, wD_MEM, wD_WB;
  logic              npc_op_EX;
  logic              mem_busy;
  logic [XLEN-1:0]   rD1_fw, rD2_fw;
  logic              rD1_fw_op, rD2_fw_op;
  logic              stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic              flush_IF_ID, flush_ID_EX, flush_MEM_WB;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt, perf_fw_cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  perf_stall_cnt, perf_flush_cnt, perf_fw_cnt,
`endif
    output wR_EX, wR_MEM, wR_WB, rf_we_EX, rf_we_MEM, rf_we_WB,
    output wb_sel_EX, wb_sel_MEM, rR1_ID, rR2_ID, rR1_use, rR2_use,
    output pc4_EX, c_EX, wD_MEM, wD_WB, npc_op_EX, mem_busy,
    input  rD1_fw, rD2_fw, rD1_fw_op, rD2_fw_op,
    input  stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    input  flush_IF_ID, flush_ID_EX, flush_MEM_WB
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output perf_stall_cnt, perf_flush_cnt, perf_fw_cnt,
`endif
    input  wR_EX, wR_MEM, wR_WB, rf_we_EX, rf_we_MEM, rf_we_WB,
    input  wb_sel_EX, wb_sel_MEM, rR1_ID, rR2_ID, rR1_use, rR2_use,
    input  pc4_EX, c_EX, wD_MEM, wD_WB, npc_op_EX, mem_busy,
    output rD1_fw, rD2_fw, rD1_fw_op, rD2_fw_op,
    output stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    output flush_IF_ID, flush_ID_EX, flush_MEM_WB
  );
endinterface

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
// rtl/hazard_ctrl_mc_fwd_sel.sv - per-operand forwarding match and priority mux
// Purpose: finds the youngest stage writing the source register and either
//          forwards its value or reports that the value is not ready yet.
// Ports: i_rr/i_use source reg; i_wr_*/i_we_*/i_wd_* per stage; i_sel_* wb
//        select; i_mem_ld_fwd allows MEM-stage load data to forward;
//        o_data/o_op forwarded value/select; o_blk_ex/o_blk_mem load blocks.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rr,
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_wr_ex,
  input  logic              i_we_ex,
  input  logic [1:0]        i_sel_ex,
  input  logic [XLEN-1:0]   i_wd_ex,
  input  logic [REG_AW-1:0] i_wr_mem,
  input  logic              i_we_mem,
  input  logic [1:0]        i_sel_mem,
  input  logic [XLEN-1:0]   i_wd_mem,
  input  logic [REG_AW-1:0] i_wr_wb,
  input  logic              i_we_wb,
  input  logic [XLEN-1:0]   i_wd_wb,
  input  logic              i_mem_ld_fwd,
  output logic [XLEN-1:0]   o_data,
  output logic              o_op,
  output logic              o_blk_ex,
  output logic              o_blk_mem
);
  logic w_hit_ex, w_hit_mem, w_hit_wb;

  assign w_hit_ex  = i_use && i_we_ex  && (i_wr_ex  == i_rr) && (i_wr_ex  != '0);
  assign w_hit_mem = i_use && i_we_mem && (i_wr_mem == i_rr) && (i_wr_mem != '0);
  assign w_hit_wb  = i_use && i_we_wb  && (i_wr_wb  == i_rr) && (i_wr_wb  != '0);

  // The youngest matching stage owns the register; an older stage's value is
  // stale, so a blocked young match must not fall through to an older one.
  always_comb begin
    o_data    = '0;
    o_op      = 1'b0;
    o_blk_ex  = 1'b0;
    o_blk_mem = 1'b0;
    if (w_hit_ex) begin
      if (i_sel_ex == WB_MEM) begin
        o_blk_ex = 1'b1;
      end else begin
        o_op   = 1'b1;
        o_data = i_wd_ex;
      end
    end else if (w_hit_mem) begin
      if ((i_sel_mem == WB_MEM) && !i_mem_ld_fwd) begin
        o_blk_mem = 1'b1;
      end else begin
        o_op   = 1'b1;
        o_data = i_wd_mem;
      end
    end else if (w_hit_wb) begin
      o_op   = 1'b1;
      o_data = i_wd_wb;
    end
  end
endmodule

// File: rtl/hazard_ctrl_mc.sv
// rtl/hazard_ctrl_mc.sv - 5-stage pipeline hazard controller
// Purpose: operand forwarding, load-use stalls (LOAD_LAT 1..2), memory-busy
//          freeze and control-hazard flushes.
// Ports: clk, rst (sync, active high); hz = hazard_ctrl_mc_if.slave carrying
//        stage info in and forwarding / stall / flush controls out.
// Macro HAZARD_PERF_CNT_EN adds saturating stall/flush/forward counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  hazard_ctrl_mc_if.slave hz
);
  localparam logic MEM_LD_FWD = (LOAD_LAT == 1);

  logic [XLEN-1:0] w_wd_ex;
  logic [XLEN-1:0] w_d1, w_d2;
  logic            w_op1, w_op2;
  logic            w_blk_ex1, w_blk_ex2, w_blk_mem1, w_blk_mem2;
  logic            w_ld_ex, w_load_use;

  hz_state_e       r_state, w_state_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic            w_s_pc, w_s_ifid, w_s_idex, w_s_exmem;
  logic            w_f_ifid, w_f_idex, w_f_memwb;

  assign w_wd_ex = (hz.wb_sel_EX == WB_PC4) ? hz.pc4_EX : hz.c_EX;

  fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
    .i_rr(hz.rR1_ID), .i_use(hz.rR1_use),
    .i_wr_ex(hz.wR_EX), .i_we_ex(hz.rf_we_EX), .i_sel_ex(hz.wb_sel_EX), .i_wd_ex(w_wd_ex),
    .i_wr_mem(hz.wR_MEM), .i_we_mem(hz.rf_we_MEM), .i_sel_mem(hz.wb_sel_MEM), .i_wd_mem(hz.wD_MEM),
    .i_wr_wb(hz.wR_WB), .i_we_wb(hz.rf_we_WB), .i_wd_wb(hz.wD_WB),
    .i_mem_ld_fwd(MEM_LD_FWD),
    .o_data(w_d1), .o_op(w_op1), .o_blk_ex(w_blk_ex1), .o_blk_mem(w_blk_mem1)
  );

  fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
    .i_rr(hz.rR2_ID), .i_use(hz.rR2_use),
    .i_wr_ex(hz.wR_EX), .i_we_ex(hz.rf_we_EX), .i_sel_ex(hz.wb_sel_EX), .i_wd_ex(w_wd_ex),
    .i_wr_mem(hz.wR_MEM), .i_we_mem(hz.rf_we_MEM), .i_sel_mem(hz.wb_sel_MEM), .i_wd_mem(hz.wD_MEM),
    .i_wr_wb(hz.wR_WB), .i_we_wb(hz.rf_we_WB), .i_wd_wb(hz.wD_WB),
    .i_mem_ld_fwd(MEM_LD_FWD),
    .o_data(w_d2), .o_op(w_op2), .o_blk_ex(w_blk_ex2), .o_blk_mem(w_blk_mem2)
  );

  // MEM blocks only occur when MEM load data cannot forward (LOAD_LAT==2).
  assign w_ld_ex    = w_blk_ex1 | w_blk_ex2;
  assign w_load_use = w_ld_ex | w_blk_mem1 | w_blk_mem2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_pc      = 1'b0;
    w_s_ifid    = 1'b0;
    w_s_idex    = 1'b0;
    w_s_exmem   = 1'b0;
    w_f_ifid    = 1'b0;
    w_f_idex    = 1'b0;
    w_f_memwb   = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.mem_busy) begin
          w_state_nxt = MEM_WAIT;
        end else if (hz.npc_op_EX) begin
          w_f_ifid = 1'b1;
          w_f_idex = 1'b1;
        end else if (w_load_use) begin
          w_s_pc   = 1'b1;
          w_s_ifid = 1'b1;
          w_f_idex = 1'b1;
          // With a 2-cycle load the bubble must persist until the load is in WB.
          if ((LOAD_LAT == 2) && w_ld_ex) begin
            w_state_nxt = LD_STALL;
            w_cnt_nxt   = 2'd1;
          end
        end
      end
      LD_STALL: begin
        w_s_pc   = 1'b1;
        w_s_ifid = 1'b1;
        w_f_idex = 1'b1;
        if (hz.mem_busy) begin
          w_state_nxt = MEM_WAIT;
        end else if (hz.npc_op_EX) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 2'd0;
          end
        end
      end
      MEM_WAIT: begin
        w_s_pc    = 1'b1;
        w_s_ifid  = 1'b1;
        w_s_idex  = 1'b1;
        w_s_exmem = 1'b1;
        w_f_memwb = 1'b1;
        // A load bubble interrupted by the freeze resumes where it left off.
        if (!hz.mem_busy) begin
          w_state_nxt = (r_cnt != 2'd0) ? LD_STALL : RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Every output is held low while reset is asserted.
  assign hz.rD1_fw       = rst ? '0 : w_d1;
  assign hz.rD2_fw       = rst ? '0 : w_d2;
  assign hz.rD1_fw_op    = ~rst & w_op1;
  assign hz.rD2_fw_op    = ~rst & w_op2;
  assign hz.stall_PC     = ~rst & w_s_pc;
  assign hz.stall_IF_ID  = ~rst & w_s_ifid;
  assign hz.stall_ID_EX  = ~rst & w_s_idex;
  assign hz.stall_EX_MEM = ~rst & w_s_exmem;
  assign hz.flush_IF_ID  = ~rst & w_f_ifid;
  assign hz.flush_ID_EX  = ~rst & w_f_idex;
  assign hz.flush_MEM_WB = ~rst & w_f_memwb;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_flush, r_perf_fw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_fw    <= '0;
    end else begin
      if (hz.stall_PC && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (hz.flush_IF_ID && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
      if ((hz.rD1_fw_op || hz.rD2_fw_op) && (r_perf_fw != '1)) r_perf_fw <= r_perf_fw + 32'd1;
    end
  end

  assign hz.perf_stall_cnt = r_perf_stall;
  assign hz.perf_flush_cnt = r_perf_flush;
  assign hz.perf_fw_cnt    = r_perf_fw;
`endif
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb/tb_hazard_ctrl_mc.sv - scoreboard bench for hazard_ctrl_mc (LOAD_LAT 1 and 2)
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  logic clk;
  logic rst;
  logic [4:0]  wR_EX, wR_MEM, wR_WB, rR1_ID, rR2_ID;
  logic        rf_we_EX, rf_we_MEM, rf_we_WB, rR1_use, rR2_use, npc_op_EX, mem_busy;
  logic [1:0]  wb_sel_EX, wb_sel_MEM;
  logic [31:0] pc4_EX, c_EX, wD_MEM, wD_WB;

  hazard_ctrl_mc_if #(.XLEN(32), .REG_AW(5)) if_a ();
  hazard_ctrl_mc_if #(.XLEN(32), .REG_AW(5)) if_b ();

  hazard_ctrl_mc #(.XLEN(32), .REG_AW(5), .LOAD_LAT(1)) dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
  hazard_ctrl_mc #(.XLEN(32), .REG_AW(5), .LOAD_LAT(2)) dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));

  assign if_a.wR_EX = wR_EX;          assign if_b.wR_EX = wR_EX;
  assign if_a.wR_MEM = wR_MEM;        assign if_b.wR_MEM = wR_MEM;
  assign if_a.wR_WB = wR_WB;          assign if_b.wR_WB = wR_WB;
  assign if_a.rf_we_EX = rf_we_EX;    assign if_b.rf_we_EX = rf_we_EX;
  assign if_a.rf_we_MEM = rf_we_MEM;  assign if_b.rf_we_MEM = rf_we_MEM;
  assign if_a.rf_we_WB = rf_we_WB;    assign if_b.rf_we_WB = rf_we_WB;
  assign if_a.wb_sel_EX = wb_sel_EX;  assign if_b.wb_sel_EX = wb_sel_EX;
  assign if_a.wb_sel_MEM = wb_sel_MEM; assign if_b.wb_sel_MEM = wb_sel_MEM;
  assign if_a.rR1_ID = rR1_ID;        assign if_b.rR1_ID = rR1_ID;
  assign if_a.rR2_ID = rR2_ID;        assign if_b.rR2_ID = rR2_ID;
  assign if_a.rR1_use = rR1_use;      assign if_b.rR1_use = rR1_use;
  assign if_a.rR2_use = rR2_use;      assign if_b.rR2_use = rR2_use;
  assign if_a.pc4_EX = pc4_EX;        assign if_b.pc4_EX = pc4_EX;
  assign if_a.c_EX = c_EX;            assign if_b.c_EX = c_EX;
  assign if_a.wD_MEM = wD_MEM;        assign if_b.wD_MEM = wD_MEM;
  assign if_a.wD_WB = wD_WB;          assign if_b.wD_WB = wD_WB;
  assign if_a.npc_op_EX = npc_op_EX;  assign if_b.npc_op_EX = npc_op_EX;
  assign if_a.mem_busy = mem_busy;    assign if_b.mem_busy = mem_busy;

  // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, flush_MEM_WB, fw_op1, fw_op2}
  logic [8:0] ctl_a, ctl_b;
  assign ctl_a = {if_a.stall_PC, if_a.stall_IF_ID, if_a.stall_ID_EX, if_a.stall_EX_MEM,
                  if_a.flush_IF_ID, if_a.flush_ID_EX, if_a.flush_MEM_WB, if_a.rD1_fw_op, if_a.rD2_fw_op};
  assign ctl_b = {if_b.stall_PC, if_b.stall_IF_ID, if_b.stall_ID_EX, if_b.stall_EX_MEM,
                  if_b.flush_IF_ID, if_b.flush_ID_EX, if_b.flush_MEM_WB, if_b.rD1_fw_op, if_b.rD2_fw_op};

  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LD   = 9'b110001000;
  localparam logic [8:0] C_FRZ  = 9'b111100100;
  localparam logic [8:0] C_RED  = 9'b000011000;
  localparam logic [8:0] OP1    = 9'b000000010;
  localparam logic [8:0] OP2    = 9'b000000001;

  typedef struct {
    logic [8:0]  ca;
    logic [31:0] a1, a2;
    logic [8:0]  cb;
    logic [31:0] b1, b2;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push2(input logic [8:0] ca, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [8:0] cb, input logic [31:0] b1, input logic [31:0] b2);
    exp_t e;
    e.ca = ca; e.a1 = a1; e.a2 = a2; e.cb = cb; e.b1 = b1; e.b2 = b2;
    sb_q.push_back(e);
  endtask

  task automatic push1(input logic [8:0] c, input logic [31:0] d1, input logic [31:0] d2);
    push2(c, d1, d2, c, d1, d2);
  endtask

  // Inputs are applied just after a falling edge; outputs are sampled 1ns later.
  task automatic cycle();
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      chk($sformatf("s%0d.sb_underflow", step_no), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("s%0d.ctl_a", step_no), {23'd0, ctl_a}, {23'd0, e.ca});
      chk($sformatf("s%0d.d1_a", step_no), if_a.rD1_fw, e.a1);
      chk($sformatf("s%0d.d2_a", step_no), if_a.rD2_fw, e.a2);
      chk($sformatf("s%0d.ctl_b", step_no), {23'd0, ctl_b}, {23'd0, e.cb});
      chk($sformatf("s%0d.d1_b", step_no), if_b.rD1_fw, e.b1);
      chk($sformatf("s%0d.d2_b", step_no), if_b.rD2_fw, e.b2);
    end
    step_no++;
    @(negedge clk);
  endtask

  task automatic idle();
    wR_EX = 0; wR_MEM = 0; wR_WB = 0; rR1_ID = 0; rR2_ID = 0;
    rf_we_EX = 0; rf_we_MEM = 0; rf_we_WB = 0; rR1_use = 0; rR2_use = 0;
    wb_sel_EX = WB_ALU; wb_sel_MEM = WB_ALU;
    pc4_EX = 32'h44; c_EX = 32'h11; wD_MEM = 32'h55; wD_WB = 32'h66;
    npc_op_EX = 0; mem_busy = 0;
  endtask

  task automatic ex_alu_x5();
    wR_EX = 5; rf_we_EX = 1; wb_sel_EX = WB_ALU; c_EX = 32'h11; rR1_ID = 5; rR1_use = 1;
  endtask

  task automatic ex_load_x3();
    wR_EX = 3; rf_we_EX = 1; wb_sel_EX = WB_MEM; c_EX = 32'h99; rR2_ID = 3; rR2_use = 1;
  endtask

  initial begin
    rst = 1; idle(); ex_alu_x5();
    @(negedge clk); @(negedge clk);
    // reset holds every output low even with a live match
    push1(C_NONE, 0, 0); cycle();
    // forwarding priority EX > MEM > WB
    rst = 0;
    wR_MEM = 5; rf_we_MEM = 1; wD_MEM = 32'h22; wR_WB = 5; rf_we_WB = 1; wD_WB = 32'h33;
    rR2_ID = 0; rR2_use = 1;
    push1(OP1, 32'h11, 0); cycle();
    wb_sel_EX = WB_PC4; pc4_EX = 32'h44;
    push1(OP1, 32'h44, 0); cycle();
    rf_we_EX = 0; rR2_ID = 5; rR2_use = 0;
    push1(OP1, 32'h22, 0); cycle();
    rf_we_MEM = 0; rR2_use = 1;
    push1(OP1 | OP2, 32'h33, 32'h33); cycle();
    // x0 never forwards or stalls
    idle(); wR_EX = 0; rf_we_EX = 1; rR1_ID = 0; rR1_use = 1;
    push1(C_NONE, 0, 0); cycle();
    // load-use: LAT1 stalls once then forwards from MEM; LAT2 stalls twice then WB
    idle(); ex_load_x3();
    push1(C_LD, 0, 0); cycle();
    rf_we_EX = 0; wR_MEM = 3; rf_we_MEM = 1; wb_sel_MEM = WB_MEM; wD_MEM = 32'h55;
    push2(OP2, 0, 32'h55, C_LD, 0, 0); cycle();
    rf_we_MEM = 0; wR_WB = 3; rf_we_WB = 1; wD_WB = 32'h66;
    push1(OP2, 0, 32'h66); cycle();
    // memory freeze in the middle of a LAT2 load stall
    idle(); ex_load_x3();
    push1(C_LD, 0, 0); cycle();
    rf_we_EX = 0; wR_MEM = 3; rf_we_MEM = 1; wb_sel_MEM = WB_MEM; mem_busy = 1;
    push2(OP2, 0, 32'h55, C_LD, 0, 0); cycle();
    push2(C_FRZ | OP2, 0, 32'h55, C_FRZ, 0, 0); cycle();
    push2(C_FRZ | OP2, 0, 32'h55, C_FRZ, 0, 0); cycle();
    mem_busy = 0;
    push2(C_FRZ | OP2, 0, 32'h55, C_FRZ, 0, 0); cycle();
    push2(OP2, 0, 32'h55, C_LD, 0, 0); cycle();
    rf_we_MEM = 0; wR_WB = 3; rf_we_WB = 1;
    push1(OP2, 0, 32'h66); cycle();
    // redirect outranks load-use and does not enter LD_STALL
    idle(); ex_load_x3(); npc_op_EX = 1;
    push1(C_RED, 0, 0); cycle();
    idle();
    push1(C_NONE, 0, 0); cycle();
    // redirect is deferred while frozen
    mem_busy = 1;
    push1(C_NONE, 0, 0); cycle();
    npc_op_EX = 1;
    push1(C_FRZ, 0, 0); cycle();
    mem_busy = 0;
    push1(C_FRZ, 0, 0); cycle();
    push1(C_RED, 0, 0); cycle();
    idle();
    push1(C_NONE, 0, 0); cycle();
    // reset while in MEM_WAIT
    mem_busy = 1;
    push1(C_NONE, 0, 0); cycle();
    push1(C_FRZ, 0, 0); cycle();
    rst = 1; ex_alu_x5();
    push1(C_NONE, 0, 0); cycle();
    rst = 0; mem_busy = 0;
    push1(OP1, 32'h11, 0); cycle();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Parametrised successor to the pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It provides:
- Operand forwarding to ID from EX/MEM/WB, with EX > MEM > WB priority.
- Load-use stalls with a configurable load latency, sequenced by a counter FSM.
- Whole-pipeline freeze while a variable-latency memory access is outstanding (mem_busy handshake).
- Control-hazard flushes.
It sits beside the pipeline registers and drives their stall/flush inputs.

Parameters:
- XLEN, 32, data width of forwarded values.
- REG_AW, 5, register index width; index 0 is hardwired zero and never forwarded or stalled on.
- LOAD_LAT, 1, load-use bubble cycles: 1 = load data forwardable from MEM; 2 = load data available only at WB. Legal values 1..2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wR_EX / wR_MEM / wR_WB  in  REG_AW each  destination register per stage
- rf_we_EX / rf_we_MEM / rf_we_WB  in  1 each  register write enable per stage
- wb_sel_EX / wb_sel_MEM  in  2 each  writeback source select (encoding in package)
- rR1_ID / rR2_ID  in  REG_AW each  ID source registers
- rR1_use / rR2_use  in  1 each  source actually read
- pc4_EX  in  XLEN  PC+4 in EX
- c_EX  in  XLEN  ALU result in EX
- wD_MEM / wD_WB  in  XLEN each  writeback data in MEM / WB
- npc_op_EX  in  1  branch/jump taken, resolved in EX
- mem_busy  in  1  data memory access outstanding; MEM stage not ready
- rD1_fw / rD2_fw  out  XLEN each  forwarded operand values
- rD1_fw_op / rD2_fw_op  out  1 each  select forwarded value
- stall_PC / stall_IF_ID / stall_ID_EX / stall_EX_MEM  out  1 each  hold register
- flush_IF_ID / flush_ID_EX / flush_MEM_WB  out  1 each  insert bubble

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high. While rst=1: FSM goes to RUN, counter=0, and every stall, flush, fw_op and fw data output is 0.
- Hazard match for stage S (EX, MEM or WB) against source r: wR_S==rR_ID, rf_we_S=1, rR_use=1, wR_S!=0.
- Forwarding: first matching stage in the order EX, MEM, WB supplies rDx_fw; fw_op=1.
  - wD_EX = pc4_EX when wb_sel_EX==WB_PC4, otherwise c_EX.
  - An EX match with wb_sel_EX==WB_MEM never forwards.
  - A MEM match with wb_sel_MEM==WB_MEM forwards only when LOAD_LAT==1.
  - With no usable match: fw_op=0 and data=0.
- load_use (combinational): a usable-blocked match exists, i.e. either
  - an EX match with WB_MEM, or
  - LOAD_LAT==2 and a MEM match with WB_MEM.
- FSM states: RUN, LD_STALL, MEM_WAIT. Counter width is 2 bits.
- RUN:
  - mem_busy=1 → MEM_WAIT.
  - Else npc_op_EX=1 → flush_IF_ID=1, flush_ID_EX=1; stay in RUN.
  - Else load_use=1 → stall_PC=1, stall_IF_ID=1, flush_ID_EX=1. If LOAD_LAT==2 and the match is in EX, go to LD_STALL with counter=1; otherwise stay in RUN.
- LD_STALL: same outputs as the RUN load_use case; counter decrements; at 0 → RUN. mem_busy=1 takes priority → MEM_WAIT, and the counter is retained.
- MEM_WAIT:
  - Outputs: stall_PC=stall_IF_ID=stall_ID_EX=stall_EX_MEM=1 and flush_MEM_WB=1; no other flush asserted.
  - npc_op_EX is ignored while frozen and acted on in the first RUN cycle after release.
  - When mem_busy falls: go to LD_STALL if counter!=0, otherwise RUN.
- Priority, highest first: rst, mem_busy, npc_op_EX, load_use. A redirect in LD_STALL is impossible (EX holds a bubble); the FSM still forces RUN and clears the counter if npc_op_EX=1.
- Forwarding outputs stay combinational and valid in every state.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt (32), perf_flush_cnt (32) and perf_fw_cnt (32), all saturating and reset to 0.
  - perf_stall_cnt: +1 per cycle stall_PC=1.
  - perf_flush_cnt: +1 per cycle flush_IF_ID=1.
  - perf_fw_cnt: +1 per cycle either fw_op=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg: WB_PC4=2'd0, WB_MEM=2'd1, WB_ALU=2'd2; FSM state enum (RUN, LD_STALL, MEM_WAIT).
- One sub-module fwd_sel: per-operand match and priority mux, instantiated twice; parameters XLEN and REG_AW.

Test Plan:
- Forwarding priority: ADD x5 in EX (c_EX=0x11), x5 also in MEM (0x22) and WB (0x33), rR1_ID=5, wb_sel_EX=WB_ALU → rD1_fw=0x11, fw_op=1, no stall.
- x0 guard: wR_EX=0, rR1_ID=0 → rD1_fw_op=0, no stall.
- Load-use, LOAD_LAT=1: LW x3 in EX, rR2_ID=3 → one cycle of stall_PC/stall_IF_ID/flush_ID_EX. Next cycle the MEM match forwards wD_MEM.
- Load-use, LOAD_LAT=2: same stimulus → two stall cycles, then forward from WB.
- Memory freeze during LD_STALL: mem_busy=1 for 3 cycles → all four stalls and flush_MEM_WB high for 3 cycles, then the remaining 1 load stall cycle, then RUN.
- Redirect and reset:
  - npc_op_EX=1 with load_use=1 → flush_IF_ID=flush_ID_EX=1, stall_PC=0.
  - rst in MEM_WAIT → next cycle all outputs 0, state RUN.
